fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue slots (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port PCSrcE  input  1  redirect request from execute.
REQ-006 SHALL have port PCTargetE  input  32  redirect address.
REQ-007 SHALL have port StallD  input  1  decode stage holds its register.
REQ-008 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-009 SHALL have port imem_req_addr  output  32  fetch address, equals PCF.
REQ-010 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port imem_resp_valid  input  1  response valid; responses return in request order, latency >= 1 cycle.
REQ-012 SHALL have port imem_resp_data  input  32  instruction word.
REQ-013 SHALL have ports InstrD / PCD / PCPlus4D  output  32 each  decode register contents.
REQ-014 SHALL have port ValidD  output  1  decode register holds a real instruction.

Function
REQ-015 SHALL hold PCF; a request is accepted when imem_req_valid && imem_req_ready, then PCF <= PCF+4 (mod 2^32 wrap).
REQ-016 SHALL allocate a queue slot at acceptance, storing PCF, marked unfilled; responses fill the oldest unfilled slot.
REQ-017 SHALL assert imem_req_valid only when allocated slots < DEPTH, (discard count + unfilled slots) < DEPTH, PCSrcE low, and rst high.
REQ-018 SHALL load the decode register from the head slot when head is filled and (!StallD or !ValidD), popping the head; PCPlus4D = PCD+4.
REQ-019 SHALL, when no filled head is loadable and !StallD, load a bubble: ValidD=0, InstrD=32'h00000013 (NOP), PCD/PCPlus4D unchanged.
REQ-020 SHALL hold all decode register outputs unchanged while StallD && ValidD.
REQ-021 SHALL, on PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}; all slots cleared; ValidD <= 0, InstrD <= NOP; no request issued that cycle; flush overrides StallD.
REQ-022 SHALL set discard count at flush to the number of unfilled slots, minus one if imem_resp_valid is high that cycle (that response is dropped).
REQ-023 SHALL drop responses while discard count > 0, decrementing per response; only then do responses fill slots.
REQ-024 SHALL support simultaneous push (response fill), allocate and pop in one cycle with no loss; minimum latency request accept -> ValidD is resp latency + 1 cycle.
REQ-025 SHALL ignore imem_resp_valid when no unfilled slot and discard count = 0 (protocol error; no state change).

Reset
REQ-026 SHALL on rst=0 at a clock edge set PCF=RESET_PC, slots empty, discard=0, ValidD=0, InstrD=32'h00000013, PCD=0, PCPlus4D=0.
REQ-027 SHALL hold imem_req_valid=0 while rst=0; reset mid-transaction abandons in-flight requests without discard tracking (memory must be reset with the core).

Structure
REQ-028 SHALL take NOP constant, RESET_PC default and slot record layout (pc, instr, filled) from shared package riscv_pipe_pkg.
REQ-029 SHALL implement slot storage/pointers as sub-module fetch_slot_ring (alloc, fill, pop, clear); PC, discard and decode register in the top.

Verification
REQ-030 Reset release, ready=1, 1-cycle response latency -> req addrs 0x0,0x4,0x8...; ValidD=1 with PCD=0x0, PCPlus4D=0x4 two cycles after first accept.
REQ-031 imem_req_ready=0 for 5 cycles, responses stopped -> after 4 accepts imem_req_valid=0; ValidD holds last value with StallD=1, no slot overwrite.
REQ-032 3 requests in flight, PCSrcE=1, PCTargetE=0x103 -> next req addr 0x100; the 3 stale responses dropped; first ValidD instruction has PCD=0x100.
REQ-033 PCSrcE=1 coincident with a response and StallD=1 -> ValidD=0, InstrD=0x00000013 next cycle; discard = unfilled-1.
REQ-034 RESET_PC=0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; PCPlus4D of last = 0x4.
REQ-035 rst=0 asserted while 2 requests outstanding -> next cycle all outputs at REQ-026 values, imem_req_valid=0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared fetch/decode definitions: NOP encoding, default reset PC and the
// layout of one fetch queue slot.
package riscv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_slot_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_slot_ring.sv
// Circular store of in-flight fetches: slots are allocated in request order,
// filled in response order and popped from the head once filled.
module fetch_slot_ring
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          alloc,
    input  logic [31:0]   alloc_pc,
    input  logic          fill,
    input  logic [31:0]   fill_instr,
    input  logic          pop,
    output logic [31:0]   head_pc,
    output logic [31:0]   head_instr,
    output logic          head_ready,
    output logic [CW-1:0] used,
    output logic [CW-1:0] unfilled
);

    fetch_slot_t   slots_r [DEPTH];
    logic [PW-1:0] head_r, tail_r, fill_r;
    logic [CW-1:0] used_r, unfilled_r;
    logic          alloc_s, fill_s, pop_s;

    // Guard each operation against illegal requests so the counters never wrap.
    always_comb begin
        alloc_s    = alloc && (used_r < CW'(DEPTH));
        fill_s     = fill && (unfilled_r != {CW{1'b0}});
        head_ready = (used_r != {CW{1'b0}}) && slots_r[head_r].filled;
        pop_s      = pop && head_ready;
    end

    // Slot contents, pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            fill_r     <= {PW{1'b0}};
            used_r     <= {CW{1'b0}};
            unfilled_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '{pc: 32'h0, instr: NOP_INSTR, filled: 1'b0};
            end
        end else begin
            if (alloc_s) begin
                slots_r[tail_r] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
                tail_r          <= tail_r + PW'(1'b1);
            end
            // Responses arrive at least a cycle after allocation, so fill_r never equals tail_r here.
            if (fill_s) begin
                slots_r[fill_r].instr  <= fill_instr;
                slots_r[fill_r].filled <= 1'b1;
                fill_r                 <= fill_r + PW'(1'b1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1'b1);
            end
            used_r     <= used_r + CW'(alloc_s) - CW'(pop_s);
            unfilled_r <= unfilled_r + CW'(alloc_s) - CW'(fill_s);
        end
    end

    assign head_pc    = slots_r[head_r].pc;
    assign head_instr = slots_r[head_r].instr;
    assign used       = used_r;
    assign unfilled   = unfilled_r;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: issues PC requests, buffers responses in a
// slot ring and feeds the decode register; execute redirects flush it all.
module fetch_queue
    import riscv_pipe_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_r, instr_d_r, pc_d_r, pc_plus4_d_r;
    logic          valid_d_r;
    logic [CW-1:0] discard_r;
    logic [CW-1:0] used_s, unfilled_s;
    logic [CW:0]   outstanding_s, flush_discard_s;
    logic [31:0]   head_pc_s, head_instr_s;
    logic          head_ready_s, req_valid_s, accept_s, drop_s, fill_s, load_s;

    fetch_slot_ring #(.DEPTH(DEPTH)) u_ring (
        .clk        (clk),
        .rst        (rst),
        .clear      (PCSrcE),
        .alloc      (accept_s),
        .alloc_pc   (pc_r),
        .fill       (fill_s),
        .fill_instr (imem_resp_data),
        .pop        (load_s),
        .head_pc    (head_pc_s),
        .head_instr (head_instr_s),
        .head_ready (head_ready_s),
        .used       (used_s),
        .unfilled   (unfilled_s)
    );

    // Request gating, response routing and decode-load decision.
    always_comb begin
        outstanding_s = {1'b0, discard_r} + {1'b0, unfilled_s};
        req_valid_s   = rst && !PCSrcE && (used_s < CW'(DEPTH))
                        && (outstanding_s < (CW+1)'(DEPTH));
        accept_s      = req_valid_s && imem_req_ready;
        drop_s        = 1'b0;
        fill_s        = 1'b0;
        if (imem_resp_valid && (discard_r != {CW{1'b0}})) begin
            drop_s = 1'b1;
        end else if (imem_resp_valid && (unfilled_s != {CW{1'b0}})) begin
            fill_s = 1'b1;
        end else begin
            drop_s = 1'b0;
            fill_s = 1'b0;
        end
        // Everything still owed by memory becomes stale; a response arriving now is one of them.
        flush_discard_s = outstanding_s
                          - (CW+1)'(imem_resp_valid && (outstanding_s != {(CW+1){1'b0}}));
        load_s = !PCSrcE && head_ready_s && (!StallD || !valid_d_r);
    end

    // Fetch PC and count of stale responses to discard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r      <= RESET_PC;
            discard_r <= {CW{1'b0}};
        end else if (PCSrcE) begin
            pc_r      <= {PCTargetE[31:2], 2'b00};
            discard_r <= flush_discard_s[CW-1:0];
        end else begin
            if (accept_s) begin
                pc_r <= pc_plus4(pc_r);
            end
            if (drop_s) begin
                discard_r <= discard_r - CW'(1'b1);
            end
        end
    end

    // Decode register: flush, load from head, bubble, or hold under stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_d_r    <= 1'b0;
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0;
            pc_plus4_d_r <= 32'h0;
        end else if (PCSrcE) begin
            valid_d_r <= 1'b0;
            instr_d_r <= NOP_INSTR;
        end else if (load_s) begin
            valid_d_r    <= 1'b1;
            instr_d_r    <= head_instr_s;
            pc_d_r       <= head_pc_s;
            pc_plus4_d_r <= pc_plus4(head_pc_s);
        end else if (!StallD) begin
            valid_d_r <= 1'b0;
            instr_d_r <= NOP_INSTR;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign InstrD         = instr_d_r;
    assign PCD            = pc_d_r;
    assign PCPlus4D       = pc_plus4_d_r;
    assign ValidD         = valid_d_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: an in-order memory model with tagged
// epochs predicts requests and the decode register every cycle.
module tb_fetch_queue;
    import riscv_pipe_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, PCSrcE, StallD, imem_req_ready, imem_resp_valid;
    logic [31:0] PCTargetE, imem_resp_data;
    logic        imem_req_valid, ValidD;
    logic [31:0] imem_req_addr, InstrD, PCD, PCPlus4D;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .PCSrcE          (PCSrcE),
        .PCTargetE       (PCTargetE),
        .StallD          (StallD),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .InstrD          (InstrD),
        .PCD             (PCD),
        .PCPlus4D        (PCPlus4D),
        .ValidD          (ValidD)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          cyc;
    } mem_ent_t;

    mem_ent_t    mem_q[$];
    logic [31:0] exp_q[$];
    int          vectors = 0, miscompares = 0;
    int          cyc_cnt = 0, epoch = 0, filled_n = 0;
    logic [31:0] pc_m = RST_PC, last_pc = 32'h0, last_p4 = 32'h0, last_instr = NOP_INSTR;
    logic        valid_m = 1'b0, resp_en = 1'b1, spurious = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_cnt);
        end
    endtask

    // One clock: drive memory response, check request side, advance model, check decode side.
    task automatic step();
        logic        exp_rv, acc, flush, rsp, was_stall, in_rst;
        logic [31:0] tgt;
        mem_ent_t    ent;
        if (rst && resp_en && mem_q.size() > 0 && mem_q[0].cyc < cyc_cnt) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(mem_q[0].addr);
        end else if (rst && spurious && mem_q.size() == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        exp_rv = rst && !PCSrcE && (exp_q.size() < DEPTH) && (mem_q.size() < DEPTH);
        check_value("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (rst) check_value("imem_req_addr", imem_req_addr, pc_m);
        acc       = exp_rv && imem_req_ready;
        flush     = rst && PCSrcE;
        rsp       = imem_resp_valid;
        was_stall = StallD;
        in_rst    = !rst;
        tgt       = PCTargetE;
        @(posedge clk);
        #1;
        if (in_rst) begin
            mem_q.delete();
            exp_q.delete();
            filled_n   = 0;
            epoch++;
            pc_m       = RST_PC;
            valid_m    = 1'b0;
            last_pc    = 32'h0;
            last_p4    = 32'h0;
            last_instr = NOP_INSTR;
        end else if (flush) begin
            if (rsp && mem_q.size() > 0) ent = mem_q.pop_front();
            exp_q.delete();
            filled_n   = 0;
            epoch++;
            pc_m       = {tgt[31:2], 2'b00};
            valid_m    = 1'b0;
            last_instr = NOP_INSTR;
        end else begin
            if (filled_n > 0 && (!was_stall || !valid_m)) begin
                filled_n--;
                last_pc    = exp_q.pop_front();
                last_p4    = last_pc + 32'd4;
                last_instr = instr_of(last_pc);
                valid_m    = 1'b1;
            end else if (!was_stall) begin
                valid_m    = 1'b0;
                last_instr = NOP_INSTR;
            end
            if (rsp && mem_q.size() > 0) begin
                ent = mem_q.pop_front();
                if (ent.epoch == epoch) filled_n++;
            end
            if (acc) begin
                mem_q.push_back('{pc_m, epoch, cyc_cnt});
                exp_q.push_back(pc_m);
                pc_m = pc_m + 32'd4;
            end
        end
        cyc_cnt++;
        @(negedge clk);
        check_value("ValidD", {31'b0, ValidD}, {31'b0, valid_m});
        check_value("InstrD", InstrD, last_instr);
        check_value("PCD", PCD, last_pc);
        check_value("PCPlus4D", PCPlus4D, last_p4);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        run(2);
        // Streaming from the reset PC, crossing the 32-bit wrap.
        rst = 1'b1; imem_req_ready = 1'b1;
        run(12);
        // Backpressure: responses stopped, decode stalled, then memory not ready.
        StallD = 1'b1; resp_en = 1'b0;
        run(6);
        imem_req_ready = 1'b0;
        run(5);
        StallD = 1'b0; resp_en = 1'b1; imem_req_ready = 1'b1;
        run(8);
        // Redirect with three requests in flight, unaligned target.
        imem_req_ready = 1'b0;
        run(4);
        imem_req_ready = 1'b1; resp_en = 1'b0;
        run(3);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0103; resp_en = 1'b1;
        run(1);
        PCSrcE = 1'b0;
        run(10);
        // Redirect coinciding with a response while decode is stalled.
        StallD = 1'b1;
        run(3);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_2000;
        run(1);
        PCSrcE = 1'b0; StallD = 1'b0;
        run(8);
        // Unsolicited response with nothing outstanding.
        imem_req_ready = 1'b0;
        run(4);
        spurious = 1'b1;
        run(1);
        spurious = 1'b0; imem_req_ready = 1'b1;
        run(4);
        // Mixed random traffic.
        for (int i = 0; i < 300; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            StallD         = ($urandom_range(0, 3) == 0);
            resp_en        = ($urandom_range(0, 4) != 0);
            PCSrcE         = ($urandom_range(0, 19) == 0);
            PCTargetE      = $urandom;
            step();
        end
        // Reset with two requests outstanding.
        PCSrcE = 1'b0; StallD = 1'b0; imem_req_ready = 1'b1; resp_en = 1'b0;
        run(2);
        rst = 1'b0;
        run(1);
        rst = 1'b1; resp_en = 1'b1;
        run(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
